// File: rtl/multicycle_controller.sv
// Multicycle RV32I control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and decodes every datapath select
// and write strobe from the current state.
module multicycle_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Instr_i,
    input  logic                  Zero_i,
    input  logic                  MemReady_i,
    output logic                  PCWrite_o,
    output logic                  AdrSrc_o,
    output logic                  IRWrite_o,
    output logic                  MemWrite_o,
    output logic                  RegWrite_o,
    output logic [1:0]            ResultSrc_o,
    output logic [1:0]            ALUSrcA_o,
    output logic [1:0]            ALUSrcB_o,
    output logic [3:0]            ALUCtrl_o,
    output logic [2:0]            ImmSrc_o,
    output logic                  InstrDone_o,
    output logic                  Fault_o
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_LUI,
        S_AUIPC,
        S_FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_IALU   = 7'd19;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_AUIPC  = 7'd23;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    state_t r_state;
    state_t w_stateNext;

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic                  w_bit30;
    logic [3:0]            w_aluFunct;
    logic [DATA_WIDTH-12:0] w_unused;

    assign w_opcode = Instr_i[6:0];
    assign w_funct3 = Instr_i[14:12];
    assign w_bit30  = Instr_i[30];
    // Register indices and immediate payload bits belong to the datapath, not here.
    assign w_unused = {Instr_i[DATA_WIDTH-1:31], Instr_i[29:15], Instr_i[11:7]};

    // State register; reset returns to FETCH at once, even mid-stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc_o = 3'b000;
        case (w_opcode)
            OP_STORE:         ImmSrc_o = 3'b001;
            OP_BRANCH:        ImmSrc_o = 3'b010;
            OP_LUI, OP_AUIPC: ImmSrc_o = 3'b011;
            OP_JAL:           ImmSrc_o = 3'b100;
            default:          ImmSrc_o = 3'b000;
        endcase
    end

    // ALU function for EXECR/EXECI; bit 30 selects SUB only for R-type, SRA for both.
    always_comb begin
        w_aluFunct = ALU_ADD;
        case (w_funct3)
            3'b000: w_aluFunct = ((w_opcode == OP_RTYPE) && w_bit30) ? ALU_SUB : ALU_ADD;
            3'b001: w_aluFunct = ALU_SLL;
            3'b010: w_aluFunct = ALU_SLT;
            3'b011: w_aluFunct = ALU_SLTU;
            3'b100: w_aluFunct = ALU_XOR;
            3'b101: w_aluFunct = w_bit30 ? ALU_SRA : ALU_SRL;
            3'b110: w_aluFunct = ALU_OR;
            3'b111: w_aluFunct = ALU_AND;
            default: w_aluFunct = ALU_ADD;
        endcase
    end

    // Next state and Moore outputs, gated only by MemReady_i and Zero_i.
    always_comb begin
        w_stateNext = r_state;
        PCWrite_o   = 1'b0;
        AdrSrc_o    = 1'b0;
        IRWrite_o   = 1'b0;
        MemWrite_o  = 1'b0;
        RegWrite_o  = 1'b0;
        ResultSrc_o = 2'b00;
        ALUSrcA_o   = 2'b00;
        ALUSrcB_o   = 2'b00;
        ALUCtrl_o   = ALU_ADD;
        InstrDone_o = 1'b0;
        Fault_o     = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
                PCWrite_o   = MemReady_i;
                IRWrite_o   = MemReady_i;
                if (MemReady_i) w_stateNext = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b01;
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_stateNext = S_MEMADR;
                    OP_RTYPE:          w_stateNext = S_EXECR;
                    OP_IALU:           w_stateNext = S_EXECI;
                    OP_BRANCH:         w_stateNext = (w_funct3[2:1] == 2'b00) ? S_BRANCH : S_FAULT;
                    OP_JAL:            w_stateNext = S_JAL;
                    OP_JALR:           w_stateNext = S_JALR;
                    OP_LUI:            w_stateNext = S_LUI;
                    OP_AUIPC:          w_stateNext = S_AUIPC;
                    default:           w_stateNext = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o   = 2'b10;
                ALUSrcB_o   = 2'b01;
                w_stateNext = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc_o = 1'b1;
                if (MemReady_i) w_stateNext = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc_o = 2'b01;
                RegWrite_o  = 1'b1;
                InstrDone_o = 1'b1;
                w_stateNext = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc_o    = 1'b1;
                MemWrite_o  = 1'b1;
                InstrDone_o = MemReady_i;
                if (MemReady_i) w_stateNext = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA_o   = 2'b10;
                ALUCtrl_o   = w_aluFunct;
                w_stateNext = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA_o   = 2'b10;
                ALUSrcB_o   = 2'b01;
                ALUCtrl_o   = w_aluFunct;
                w_stateNext = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite_o  = 1'b1;
                InstrDone_o = 1'b1;
                w_stateNext = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o   = 2'b10;
                ALUCtrl_o   = ALU_SUB;
                PCWrite_o   = Zero_i ^ w_funct3[0];
                InstrDone_o = 1'b1;
                w_stateNext = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA_o   = 2'b01;
                ALUSrcB_o   = 2'b10;
                PCWrite_o   = 1'b1;
                w_stateNext = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA_o   = 2'b10;
                ALUSrcB_o   = 2'b01;
                ResultSrc_o = 2'b10;
                PCWrite_o   = 1'b1;
                w_stateNext = S_LINK;
            end
            S_LINK: begin
                ALUSrcA_o   = 2'b01;
                ALUSrcB_o   = 2'b10;
                w_stateNext = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA_o   = 2'b11;
                ALUSrcB_o   = 2'b01;
                w_stateNext = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA_o   = 2'b01;
                ALUSrcB_o   = 2'b01;
                w_stateNext = S_ALUWB;
            end
            S_FAULT: begin
                Fault_o     = 1'b1;
                w_stateNext = S_FAULT;
            end
            default: begin
                w_stateNext = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into a list of
// expected per-cycle behaviours, then driven cycle by cycle with random
// memory stalls and zero flags, comparing every output each cycle.
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        memReady;
    logic        pcWrite, adrSrc, irWrite, memWrite, regWrite, instrDone, fault;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB;
    logic [3:0]  aluCtrl;
    logic [2:0]  immSrc;
    logic [19:0] obsVec;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // One expected cycle: selects are fixed, strobes may depend on ready/zero.
    typedef struct {
        logic       adr;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic [3:0] alu;
        int         pcw;      // 0 never, 1 always, 2 when ready, 3 branch taken
        logic       irwReady;
        logic       mw;
        logic       rw;
        logic       waitMem;
        int         done;     // 0 never, 1 always, 2 when ready
        logic       fault;
    } phase_t;

    phase_t phaseQ[$];

    multicycle_controller #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .Instr_i     (instr),
        .Zero_i      (zero),
        .MemReady_i  (memReady),
        .PCWrite_o   (pcWrite),
        .AdrSrc_o    (adrSrc),
        .IRWrite_o   (irWrite),
        .MemWrite_o  (memWrite),
        .RegWrite_o  (regWrite),
        .ResultSrc_o (resultSrc),
        .ALUSrcA_o   (aluSrcA),
        .ALUSrcB_o   (aluSrcB),
        .ALUCtrl_o   (aluCtrl),
        .ImmSrc_o    (immSrc),
        .InstrDone_o (instrDone),
        .Fault_o     (fault)
    );

    assign obsVec = {pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc,
                     aluSrcA, aluSrcB, aluCtrl, immSrc, instrDone, fault};

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic phase_t ph(input logic adr, input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] res, input logic [3:0] alu, input int pcw,
                                  input logic irwReady, input logic mw, input logic rw,
                                  input logic waitMem, input int done, input logic flt);
        phase_t p;
        p.adr = adr; p.a = a; p.b = b; p.res = res; p.alu = alu; p.pcw = pcw;
        p.irwReady = irwReady; p.mw = mw; p.rw = rw; p.waitMem = waitMem;
        p.done = done; p.fault = flt;
        return p;
    endfunction

    function automatic bit isLegal(input logic [31:0] ins);
        case (ins[6:0])
            7'd3, 7'd35, 7'd51, 7'd19, 7'd111, 7'd103, 7'd55, 7'd23: return 1'b1;
            7'd99: return (ins[14:12] == 3'd0) || (ins[14:12] == 3'd1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int cpiFor(input logic [31:0] ins);
        case (ins[6:0])
            7'd3, 7'd103: return 5;
            7'd99:        return 3;
            default:      return 4;
        endcase
    endfunction

    function automatic logic [2:0] immFor(input logic [31:0] ins);
        case (ins[6:0])
            7'd35:        return 3'd1;
            7'd99:        return 3'd2;
            7'd55, 7'd23: return 3'd3;
            7'd111:       return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] aluFor(input logic [31:0] ins, input bit isR);
        case (ins[14:12])
            3'd0: return (isR && ins[30]) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return ins[30] ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [19:0] expVec(input phase_t p, input logic [31:0] ins,
                                           input logic mr, input logic z);
        logic pcw, irw, done;
        pcw  = (p.pcw == 1) || (p.pcw == 2 && mr) || (p.pcw == 3 && (z ^ ins[12]));
        irw  = p.irwReady & mr;
        done = (p.done == 1) || (p.done == 2 && mr);
        return {pcw, p.adr, irw, p.mw, p.rw, p.res, p.a, p.b, p.alu, immFor(ins), done, p.fault};
    endfunction

    function automatic phase_t fetchPhase();
        return ph(0, 2'b00, 2'b10, 2'b10, 4'd0, 2, 1, 0, 0, 1, 0, 0);
    endfunction

    // Expected sequence of cycles for one instruction.
    task automatic buildPhases(input logic [31:0] ins);
        phase_t wb;
        wb = ph(0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0, 0, 1, 0, 1, 0);
        phaseQ.delete();
        phaseQ.push_back(fetchPhase());
        phaseQ.push_back(ph(0, 2'b01, 2'b01, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 0));
        if (!isLegal(ins)) begin
            repeat (12) phaseQ.push_back(ph(0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
            case (ins[6:0])
                7'd3: begin
                    phaseQ.push_back(ph(0, 2'b10, 2'b01, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(ph(1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0, 0, 0, 1, 0, 0));
                    phaseQ.push_back(ph(0, 2'b00, 2'b00, 2'b01, 4'd0, 0, 0, 0, 1, 0, 1, 0));
                end
                7'd35: begin
                    phaseQ.push_back(ph(0, 2'b10, 2'b01, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(ph(1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0, 1, 0, 1, 2, 0));
                end
                7'd51: begin
                    phaseQ.push_back(ph(0, 2'b10, 2'b00, 2'b00, aluFor(ins, 1), 0, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(wb);
                end
                7'd19: begin
                    phaseQ.push_back(ph(0, 2'b10, 2'b01, 2'b00, aluFor(ins, 0), 0, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(wb);
                end
                7'd99: begin
                    phaseQ.push_back(ph(0, 2'b10, 2'b00, 2'b00, 4'd1, 3, 0, 0, 0, 0, 1, 0));
                end
                7'd111: begin
                    phaseQ.push_back(ph(0, 2'b01, 2'b10, 2'b00, 4'd0, 1, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(wb);
                end
                7'd103: begin
                    phaseQ.push_back(ph(0, 2'b10, 2'b01, 2'b10, 4'd0, 1, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(ph(0, 2'b01, 2'b10, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(wb);
                end
                7'd55: begin
                    phaseQ.push_back(ph(0, 2'b11, 2'b01, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(wb);
                end
                default: begin
                    phaseQ.push_back(ph(0, 2'b01, 2'b01, 2'b00, 4'd0, 0, 0, 0, 0, 0, 0, 0));
                    phaseQ.push_back(wb);
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic z);
        @(negedge clk);
        memReady = mr;
        zero     = z;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [19:0] expected);
        checkCount++;
        assert (obsVec === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obsVec, expected);
        end
    endtask

    task automatic checkInt(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one instruction to completion; zeroMode 0/1 fixed, 2 random.
    task automatic runInstr(input string name, input logic [31:0] ins, input int memStalls,
                            input bit randStalls, input int zeroMode);
        int cycles, doneAt, stalls, consec;
        logic mr, z;
        buildPhases(ins);
        instr  = ins;
        cycles = 0;
        doneAt = 0;
        stalls = 0;
        foreach (phaseQ[k]) begin
            consec = 0;
            do begin
                if (phaseQ[k].waitMem) begin
                    if (randStalls) mr = (consec >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    else if (k == 0) mr = 1'b1;
                    else mr = (consec < memStalls) ? 1'b0 : 1'b1;
                end else begin
                    mr = 1'($urandom_range(0, 1));
                end
                z = (zeroMode == 2) ? 1'($urandom_range(0, 1)) : 1'(zeroMode);
                applyStimulus(mr, z);
                cycles++;
                checkOutput($sformatf("%s cycle %0d", name, cycles), expVec(phaseQ[k], ins, mr, z));
                if (instrDone === 1'b1 && doneAt == 0) doneAt = cycles;
                if (phaseQ[k].waitMem && !mr) begin
                    stalls++;
                    consec++;
                end
                @(posedge clk);
            end while (phaseQ[k].waitMem && !mr);
        end
        checkInt({name, " done cycle"}, doneAt, isLegal(ins) ? cpiFor(ins) + stalls : 0);
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        rst      = 1'b1;
        memReady = 1'b1;
        #1;
        checkOutput({name, " in reset"}, expVec(fetchPhase(), instr, 1'b1, zero));
        @(negedge clk);
        rst      = 1'b0;
        memReady = 1'b0;
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] ins;
        logic [6:0]  ops [9];
        ops = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111, 7'd103, 7'd55, 7'd23};
        ins = $urandom;
        ins[6:0] = ops[$urandom_range(0, 8)];
        if (ins[6:0] == 7'd99) ins[14:13] = 2'b00;
        return ins;
    endfunction

    initial begin
        rst      = 1'b1;
        instr    = 32'h0;
        zero     = 1'b0;
        memReady = 1'b1;
        #12;
        checkOutput("reset ready=1", expVec(fetchPhase(), instr, 1'b1, 1'b0));
        memReady = 1'b0;
        #1;
        checkOutput("reset ready=0", expVec(fetchPhase(), instr, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed instructions");
        runInstr("add",     32'h002081B3, 0, 1'b0, 0);
        runInstr("sub",     32'h402081B3, 0, 1'b0, 0);
        runInstr("srai",    32'h4020D193, 0, 1'b0, 0);
        runInstr("lw",      32'h0002A303, 2, 1'b0, 0);
        runInstr("sw",      32'h0062A023, 3, 1'b0, 0);
        runInstr("beq z1",  32'h00208463, 0, 1'b0, 1);
        runInstr("beq z0",  32'h00208463, 0, 1'b0, 0);
        runInstr("bne z0",  32'h00209463, 0, 1'b0, 0);
        runInstr("bne z1",  32'h00209463, 0, 1'b0, 1);
        runInstr("jal",     32'h008000EF, 0, 1'b0, 0);
        runInstr("jalr",    32'h000080E7, 0, 1'b0, 0);
        runInstr("lui",     32'h123450B7, 0, 1'b0, 0);
        runInstr("auipc",   32'h00001097, 0, 1'b0, 0);

        $display("[TB] illegal instructions");
        runInstr("illegal op", 32'h0000007F, 0, 1'b0, 2);
        doReset("after illegal op");
        runInstr("illegal br", 32'h0020A463, 0, 1'b0, 2);
        doReset("after illegal br");

        $display("[TB] reset during store stall");
        instr = 32'h0062A023;
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("sw stall before reset",
                    expVec(ph(1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0, 1, 0, 1, 2, 0), instr, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("sw stall reset", expVec(fetchPhase(), instr, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        runInstr("add after reset", 32'h002081B3, 0, 1'b0, 0);

        $display("[TB] random instructions");
        for (int n = 0; n < 40; n++) begin
            runInstr($sformatf("rand%0d", n), randInstr(), 0, 1'b1, 2);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
